// File: rtl/bit_population_enumerator.sv
// Purpose: given a population count k, emit every WIDTH-bit word with exactly
// k bits set, in ascending numeric order, one word per accepted handshake.
// The successor of each word is computed combinationally (Gosper's hack), so
// with data_ready_i held high the block sustains one word per cycle.
// Ports:
//   clk_i         - system clock
//   srst_i        - synchronous reset, active-high
//   count_i       - requested population count k (0..WIDTH valid)
//   count_val_i   - count_i valid
//   count_ready_o - idle, a count can be accepted
//   data_o        - current enumerated word
//   data_val_o    - data_o valid
//   data_ready_i  - downstream accepts data_o
//   data_last_o   - data_o is the final word for this k
//   err_o         - one-cycle pulse when an out-of-range count is rejected
module bit_population_enumerator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             count_val_i,
  output logic             count_ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             data_val_o,
  input  logic             data_ready_i,
  output logic             data_last_o,
  output logic             err_o
);

  localparam int unsigned CTZ_W = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             val_q, val_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] k_q, k_d;

  logic             in_range;
  logic             out_xfer;
  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] top_mask;

  logic [WIDTH-1:0] lsb;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [CTZ_W-1:0] ctz;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] succ;

  assign in_range = (count_i <= CNT_W'(WIDTH));
  assign out_xfer = val_q && data_ready_i;
  // k low bits set: first word of a job
  assign low_mask = ~({WIDTH{1'b1}} << count_i);
  // k high bits set: final word of the current job
  assign top_mask = ~({WIDTH{1'b1}} >> k_q);

  // Gosper successor: lowest set bit, ripple it up, refill the freed ones at the bottom
  always_comb begin
    lsb  = data_q & (~data_q + WIDTH'(1));
    sum  = {1'b0, data_q} + {1'b0, lsb};
    ctz  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (lsb[i]) ctz = CTZ_W'(i);
    end
    diff = sum ^ {1'b0, data_q};
    ones = WIDTH'((diff >> 2) >> ctz);
    succ = sum[WIDTH-1:0] | ones;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_val_i && in_range) state_d = RUN;
      RUN:     if (out_xfer && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    data_d = data_q;
    val_d  = val_q;
    last_d = last_q;
    err_d  = 1'b0;
    k_d    = k_q;
    case (state_q)
      IDLE: begin
        if (count_val_i) begin
          if (in_range) begin
            data_d = low_mask;
            val_d  = 1'b1;
            last_d = (count_i == '0) || (count_i == CNT_W'(WIDTH));
            k_d    = count_i;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_xfer) begin
          if (last_q) begin
            val_d  = 1'b0;
            last_d = 1'b0;
          end else begin
            data_d = succ;
            last_d = (succ == top_mask);
          end
        end
      end
      default: begin
        val_d  = 1'b0;
        last_d = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_q <= '0;
      val_q  <= 1'b0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
      k_q    <= '0;
    end else begin
      data_q <= data_d;
      val_q  <= val_d;
      last_q <= last_d;
      err_q  <= err_d;
      k_q    <= k_d;
    end
  end

  assign count_ready_o = (state_q == IDLE);
  assign data_o        = data_q;
  assign data_val_o    = val_q;
  assign data_last_o   = last_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_bit_population_enumerator.sv
// Directed bench for bit_population_enumerator at WIDTH=4, 8 and 32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bit_population_enumerator;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic srst;

  // WIDTH=4 instance
  logic [2:0] cnt4;
  logic       cv4, rdy4, dv4, dr4, dl4, e4;
  logic [3:0] d4;
  // WIDTH=8 instance
  logic [3:0] cnt8;
  logic       cv8, rdy8, dv8, dr8, dl8, e8;
  logic [7:0] d8;
  // WIDTH=32 instance
  logic [5:0]  cnt32;
  logic        cv32, rdy32, dv32, dr32, dl32, e32;
  logic [31:0] d32;

  bit_population_enumerator #(.WIDTH(4)) u4 (
    .clk_i(clk), .srst_i(srst), .count_i(cnt4), .count_val_i(cv4),
    .count_ready_o(rdy4), .data_o(d4), .data_val_o(dv4), .data_ready_i(dr4),
    .data_last_o(dl4), .err_o(e4));

  bit_population_enumerator #(.WIDTH(8)) u8 (
    .clk_i(clk), .srst_i(srst), .count_i(cnt8), .count_val_i(cv8),
    .count_ready_o(rdy8), .data_o(d8), .data_val_o(dv8), .data_ready_i(dr8),
    .data_last_o(dl8), .err_o(e8));

  bit_population_enumerator #(.WIDTH(32)) u32 (
    .clk_i(clk), .srst_i(srst), .count_i(cnt32), .count_val_i(cv32),
    .count_ready_o(rdy32), .data_o(d32), .data_val_o(dv32), .data_ready_i(dr32),
    .data_last_o(dl32), .err_o(e32));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int popcount(input logic [31:0] x);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(x[i]);
    return n;
  endfunction

  logic [3:0]  exp4 [6];
  logic [7:0]  exp8c [5];
  logic [7:0]  prev_d;
  logic        prev_xfer;
  logic [31:0] lastw;
  int          nwords;
  bit          done;
  int          kk;

  initial begin
    exp4  = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC};
    exp8c = '{8'h0F, 8'h17, 8'h1B, 8'h1D, 8'h1E};
    srst = 1'b1;
    cnt4 = '0; cv4 = 1'b0; dr4 = 1'b0;
    cnt8 = '0; cv8 = 1'b0; dr8 = 1'b0;
    cnt32 = '0; cv32 = 1'b0; dr32 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready", 64'(rdy4), 64'(1));
    check("rst_val",   64'(dv4),  64'(0));
    check("rst_data",  64'(d4),   64'(0));
    check("rst_last",  64'(dl4),  64'(0));
    check("rst_err",   64'(e4),   64'(0));
    srst = 1'b0;

    // W4 k=2: six words back to back; a new count held during RUN is ignored
    cnt4 = 3'd2; cv4 = 1'b1; dr4 = 1'b1;
    @(negedge clk);
    cnt4 = 3'd3;
    for (int i = 0; i < 6; i++) begin
      check("a_data",  64'(d4),   64'(exp4[i]));
      check("a_val",   64'(dv4),  64'(1));
      check("a_last",  64'(dl4),  64'(i == 5));
      check("a_ready", 64'(rdy4), 64'(0));
      @(negedge clk);
    end
    cv4 = 1'b0;
    check("a_idle_ready", 64'(rdy4), 64'(1));
    check("a_idle_val",   64'(dv4),  64'(0));
    check("a_idle_last",  64'(dl4),  64'(0));
    check("a_idle_data",  64'(d4),   64'(4'hC));

    // W4 k=0: single all-zero word
    cnt4 = 3'd0; cv4 = 1'b1;
    @(negedge clk);
    cv4 = 1'b0;
    check("k0_data",  64'(d4),   64'(0));
    check("k0_val",   64'(dv4),  64'(1));
    check("k0_last",  64'(dl4),  64'(1));
    check("k0_ready", 64'(rdy4), 64'(0));
    @(negedge clk);
    check("k0_done_val",   64'(dv4),  64'(0));
    check("k0_done_ready", 64'(rdy4), 64'(1));

    // W4 k=4: single all-ones word
    cnt4 = 3'd4; cv4 = 1'b1;
    @(negedge clk);
    cv4 = 1'b0;
    check("k4_data", 64'(d4),  64'(4'hF));
    check("k4_val",  64'(dv4), 64'(1));
    check("k4_last", 64'(dl4), 64'(1));
    @(negedge clk);
    check("k4_done_val", 64'(dv4), 64'(0));

    // W4 k=5: rejected with a one-cycle error pulse
    cnt4 = 3'd5; cv4 = 1'b1;
    @(negedge clk);
    cv4 = 1'b0;
    check("err_pulse", 64'(e4),   64'(1));
    check("err_val",   64'(dv4),  64'(0));
    check("err_ready", 64'(rdy4), 64'(1));
    @(negedge clk);
    check("err_clear",  64'(e4),   64'(0));
    check("err_val2",   64'(dv4),  64'(0));
    check("err_ready2", 64'(rdy4), 64'(1));

    // W8 k=3 with random backpressure
    cnt8 = 4'd3; cv8 = 1'b1; dr8 = 1'b0;
    @(negedge clk);
    cv8 = 1'b0;
    nwords = 0; done = 1'b0; prev_d = '0; prev_xfer = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      check("b_val", 64'(dv8), 64'(1));
      check("b_pop", 64'(popcount(32'(d8))), 64'(3));
      if (cyc > 0) begin
        if (prev_xfer) check("b_ascend", 64'(d8 > prev_d), 64'(1));
        else           check("b_hold",   64'(d8), 64'(prev_d));
      end
      dr8 = 1'($urandom_range(0, 1));
      prev_d = d8;
      prev_xfer = dr8;
      if (dr8) begin
        check("b_last", 64'(dl8), 64'(nwords == 55));
        nwords++;
        if (dl8) begin
          done = 1'b1;
          check("b_final", 64'(d8), 64'(8'hE0));
        end
      end
      @(negedge clk);
    end
    dr8 = 1'b1;
    check("b_count", 64'(nwords), 64'(56));
    check("b_done_val",   64'(dv8),  64'(0));
    check("b_done_ready", 64'(rdy8), 64'(1));

    // W8 k=4 aborted by reset after five words
    cnt8 = 4'd4; cv8 = 1'b1;
    @(negedge clk);
    cv8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("c_data", 64'(d8), 64'(exp8c[i]));
      @(negedge clk);
    end
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check("c_rst_data",  64'(d8),   64'(0));
    check("c_rst_val",   64'(dv8),  64'(0));
    check("c_rst_last",  64'(dl8),  64'(0));
    check("c_rst_err",   64'(e8),   64'(0));
    check("c_rst_ready", 64'(rdy8), 64'(1));
    @(negedge clk);
    check("c_rst_quiet", 64'(dv8), 64'(0));

    // W8 k=1 after the abort: walking one
    cnt8 = 4'd1; cv8 = 1'b1;
    @(negedge clk);
    cv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("c1_data", 64'(d8),  64'(8'd1 << i));
      check("c1_last", 64'(dl8), 64'(i == 7));
      @(negedge clk);
    end
    check("c1_done_val", 64'(dv8), 64'(0));

    // W32 k=1 and k=31: popcount loopback
    for (int t = 0; t < 2; t++) begin
      kk = (t == 0) ? 1 : 31;
      cnt32 = 6'(kk); cv32 = 1'b1; dr32 = 1'b1;
      @(negedge clk);
      cv32 = 1'b0;
      nwords = 0; lastw = '0;
      for (int cyc = 0; cyc < 100 && dv32; cyc++) begin
        check("d_pop", 64'(popcount(d32)), 64'(kk));
        lastw = d32;
        nwords++;
        @(negedge clk);
      end
      check("d_count", 64'(nwords), 64'(32));
      check("d_final", 64'(lastw), (t == 0) ? 64'(32'h8000_0000) : 64'(32'hFFFF_FFFE));
      check("d_ready", 64'(rdy32), 64'(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_population_enumerator.md
Name: bit_population_enumerator

Overview:
- Inverse companion of the bit population counter: accepts a population count k and emits every WIDTH-bit word whose popcount equals k.
- Words come out in ascending numeric order, one per accepted handshake, with a last flag on the final word.
- Used as a stimulus/pattern source in front of the population counter, and for exhaustive weight-class sweeps.
- Sits in the clk_i domain behind the usual input/output register stage of the top wrapper.

Parameters:
- WIDTH, 32, word width in bits; must be ≥2.
- CNT_W, $clog2(WIDTH)+1, width of the count input; covers 0..WIDTH.

Ports:
- clk_i  input  1  system clock.
- srst_i  input  1  synchronous reset, active-high.
- count_i  input  CNT_W  requested population count k.
- count_val_i  input  1  count_i valid.
- count_ready_o  output  1  enumerator idle, can accept a count.
- data_o  output  WIDTH  current enumerated word.
- data_val_o  output  1  data_o valid.
- data_ready_i  input  1  downstream accepts data_o.
- data_last_o  output  1  data_o is the final word for this k.
- err_o  output  1  one-cycle pulse: an out-of-range count was rejected.

Behaviour:
- Clock and reset: one clock, clk_i. srst_i is synchronous and active-high. All state updates on posedge clk_i.
- Reset values (cycle after srst_i sampled high): state=IDLE, data_o=0, data_val_o=0, data_last_o=0, err_o=0, count_ready_o=1.
- count_ready_o = (state==IDLE), decoded from the state register.
- data_last_o and err_o are registered.
- State IDLE:
  - Input transfer is count_val_i && count_ready_o.
  - k ≤ WIDTH: next cycle data_o=(1<<k)-1 (k low bits set), data_val_o=1, state=RUN. data_last_o=1 iff k==0 or k==WIDTH.
  - k > WIDTH: no output, state stays IDLE, err_o=1 for exactly one cycle.
- State RUN:
  - count_ready_o=0; count_i and count_val_i are ignored.
  - Output transfer is data_val_o && data_ready_i.
  - Without a transfer, data_o, data_val_o and data_last_o hold stable (backpressure, no drops).
  - On a transfer with data_last_o=0: data_o ← successor, and data_last_o ← (successor == ((1<<k)-1) << (WIDTH-k)).
  - On a transfer with data_last_o=1: state=IDLE, data_val_o=0, data_last_o=0, data_o keeps its last value.
- Successor (Gosper), x = data_o:
  - c = x & (~x+1);
  - r = x + c, computed in WIDTH+1 bits;
  - ones = ((r ^ x) >> 2) >> ctz(x), where ctz comes from a priority encoder on c; no divider;
  - next = r[WIDTH-1:0] | ones.
  - The overflow carry r[WIDTH] is never reached, because last detection happens one word earlier.
- Latency and throughput:
  - Count accepted at cycle T → first word valid at T+1.
  - With data_ready_i held high, one word per cycle: exactly C(WIDTH,k) words, last on the final one.
  - After the last transfer, count_ready_o=1 in the following cycle (one-cycle bubble between jobs).
- Critical path: WIDTH-bit add plus shift. At WIDTH=32 it must close at 150 MHz. If it does not, pipeline the successor one stage and deassert data_val_o for one cycle between words; document the resulting throughput.
- Reset mid-operation: srst_i in RUN aborts the job. Next cycle is the reset state; no further words are emitted.
- Simultaneous events: count_val_i asserted during RUN, including in the same cycle as the last transfer, is not accepted. The upstream must hold it until count_ready_o=1.

Test Plan:
- WIDTH=4, count_i=2, data_ready_i=1 → words 0011, 0101, 0110, 1001, 1010, 1100 on consecutive cycles. data_last_o=1 only on 1100; count_ready_o=1 one cycle later.
- WIDTH=4, count_i=0 → single word 0000 with data_last_o=1. Then count_i=4 → single word 1111 with data_last_o=1.
- WIDTH=4, count_i=5 → err_o high exactly 1 cycle, data_val_o stays 0, count_ready_o stays 1.
- WIDTH=8, count_i=3, data_ready_i random 50% → 56 distinct words, strictly ascending, each with popcount 3. data_o is stable while data_ready_i=0; last word is 11100000.
- WIDTH=8, count_i=4, srst_i pulsed after the 5th word → all outputs at reset values next cycle. A new count_i=1 then yields 00000001…10000000, 8 words.
- WIDTH=32 loopback: enumerator feeds the population counter, k=1 and k=31 → every counter result equals k, and 32 words are seen for each.
